fp_accumulator: RTL and testbench

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

---
 rtl/fp_accumulator.sv | 94 +++++++++
 tb/tb_fp_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// Packet-wise single-precision accumulator driving an external combinational fp adder.
// Define FP_ACC_SPECIAL_EN to skip Inf/NaN operands and flag them on the invalid output.
module fp_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             invalid,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_s
);

  typedef enum logic {ACC, OUT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               invalid_q, invalid_d;
  logic               special_beat;

`ifdef FP_ACC_SPECIAL_EN
  assign special_beat = &in_data[30:23];
`else
  assign special_beat = 1'b0;
`endif

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign invalid   = invalid_q;

  // The acc register doubles as the result register, so the sum is visible one cycle after the last beat.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    invalid_d = invalid_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (special_beat) begin
            invalid_d = 1'b1;
          end else begin
            acc_d = add_s;
            if (count_q != {CNT_W{1'b1}}) begin
              count_d = count_q + CNT_W'(1);
            end
          end
          if (in_last) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d   = ACC;
          acc_d     = 32'h0000_0000;
          count_d   = '0;
          invalid_d = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= 32'h0000_0000;
      count_q   <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      invalid_q <= invalid_d;
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: directed cases plus random integer-valued packets
// compared against an integer-sum reference; the external adder is modelled with real arithmetic.
module tb_fp_accumulator;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             invalid;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_s;

  int compared = 0;
  int mismatched = 0;

  fp_accumulator #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .invalid(invalid),
    .add_a(add_a), .add_b(add_b), .add_s(add_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-precision <-> double conversions; only normal numbers and zero are exercised.
  function automatic real fp2real(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'h00 || f[30:23] == 8'hFF) return 0.0;
    b = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] real2fp(input real x);
    logic [63:0] b;
    if (x == 0.0) return 32'h0000_0000;
    b = $realtobits(x);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int          a;
    int          msb;
    logic [31:0] m;
    if (v == 0) return 32'h0000_0000;
    a = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 31; i++) if (a[i]) msb = i;
    m = 32'(a) << (23 - msb);
    return {(v < 0), 8'(127 + msb), m[22:0]};
  endfunction

  always_comb add_s = real2fp(fp2real(add_a) + fp2real(add_b));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input bit l, input int idle);
    int waited;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("beat_accept_timeout", 64'(in_ready), 64'd1);
    checkOutput("add_b_follows_in_data", 64'(add_b), 64'(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_result(input string tag, input logic [31:0] ed, input int ec, input bit ei, input int hold);
    @(negedge clk);
    checkOutput({tag, "_latency"}, 64'(out_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      checkOutput({tag, "_hold_data"}, 64'(out_data), 64'(ed));
      checkOutput({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    checkOutput({tag, "_data"}, 64'(out_data), 64'(ed));
    checkOutput({tag, "_count"}, 64'(out_count), 64'(ec));
    checkOutput({tag, "_invalid"}, 64'(invalid), 64'(ei));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_released"}, 64'(out_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int len;
    int sum;
    int v;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_count", 64'(out_count), 64'd0);
    checkOutput("reset_invalid", 64'(invalid), 64'd0);
    checkOutput("reset_acc", 64'(add_a), 64'd0);

    applyStimulus(32'h3F80_0000, 1'b0, 0);
    applyStimulus(32'h4000_0000, 1'b1, 0);
    recv_result("one_plus_two", 32'h4040_0000, 2, 1'b0, 0);

    applyStimulus(32'hC0A0_0000, 1'b1, 1);
    recv_result("single_beat", 32'hC0A0_0000, 1, 1'b0, 0);

    applyStimulus(32'h3F80_0000, 1'b0, 0);
    applyStimulus(32'hBF80_0000, 1'b1, 0);
    recv_result("cancel_to_zero", 32'h0000_0000, 2, 1'b0, 0);

    // Backpressure: a pending beat must not be swallowed while the result waits.
    applyStimulus(32'h4040_0000, 1'b1, 0);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    in_last  = 1'b1;
    recv_result("backpressure", 32'h4040_0000, 1, 1'b0, 5);
    applyStimulus(32'h40A0_0000, 1'b1, 0);
    recv_result("after_backpressure", 32'h40A0_0000, 1, 1'b0, 0);

    applyStimulus(32'h3F80_0000, 1'b0, 0);
    applyStimulus(32'h3F80_0000, 1'b0, 0);
    pulse_reset();
    applyStimulus(32'h4000_0000, 1'b1, 0);
    recv_result("reset_mid_packet", 32'h4000_0000, 1, 1'b0, 0);

    applyStimulus(32'h4100_0000, 1'b1, 0);
    pulse_reset();
    @(negedge clk);
    checkOutput("reset_in_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_out_count", 64'(out_count), 64'd0);
    applyStimulus(32'h3F80_0000, 1'b1, 0);
    recv_result("after_out_reset", 32'h3F80_0000, 1, 1'b0, 0);

`ifdef FP_ACC_SPECIAL_EN
    applyStimulus(32'h3F80_0000, 1'b0, 0);
    applyStimulus(32'h7F80_0000, 1'b0, 0);
    applyStimulus(32'h3F80_0000, 1'b1, 0);
    recv_result("skip_inf", 32'h4000_0000, 2, 1'b1, 0);
    applyStimulus(32'h3F80_0000, 1'b0, 0);
    applyStimulus(32'h7FC0_0000, 1'b1, 0);
    recv_result("nan_last", 32'h3F80_0000, 1, 1'b1, 0);
    applyStimulus(32'h4000_0000, 1'b1, 0);
    recv_result("invalid_cleared", 32'h4000_0000, 1, 1'b0, 0);
`endif

    for (int p = 0; p < 20; p++) begin
      len = int'($urandom_range(1, 6));
      sum = 0;
      for (int b = 0; b < len; b++) begin
        v = int'($urandom_range(0, 2000)) - 1000;
        sum += v;
        applyStimulus(int2fp(v), (b == len - 1), int'($urandom_range(0, 2)));
      end
      recv_result("random_packet", int2fp(sum), len, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
